// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM state type, prefix constants and ignored-code list for the PS/2 key decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GOT_E0,
        ST_GOT_F0,
        ST_GOT_E0F0
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    // Keyboard status/acknowledge bytes that never carry a key in IDLE.
    localparam int         PS2_N_IGNORED = 6;
    localparam logic [47:0] PS2_IGNORED  = {8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF};

    function automatic logic ps2_is_ignored(input logic [7:0] b);
        for (int k = 0; k < PS2_N_IGNORED; k++)
            if (b == PS2_IGNORED[k*8 +: 8]) return 1'b1;
        return 1'b0;
    endfunction

endpackage

// File: rtl/ps2_timeout_cnt.sv
// ps2_timeout_cnt: idle-cycle counter; o_tc fires on the enabled cycle that would reach TIMEOUT_CYCLES-1.
module ps2_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int W = $clog2(TIMEOUT_CYCLES);

    logic [W-1:0] r_cnt;

    assign o_tc = i_en && !i_clr && (r_cnt == W'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk) begin
        if (!rstn || i_clr || o_tc)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 make/break/extended decoder with held key, strobes and press counter.
// Define PS2_DEC_REPEAT_EN to make typematic repeats count as presses.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic [7:0] scan_code,
    output logic       key_extended,
    output logic       key_pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [7:0] press_count,
    output logic       timeout_pulse
);
    ps2_state_e r_state;

    logic w_tc, w_is_e0, w_is_f0, w_make, w_brk, w_ext, w_match, w_count;

    assign w_is_e0 = byte_in == PS2_PREFIX_EXT;
    assign w_is_f0 = byte_in == PS2_PREFIX_BRK;
    assign w_ext   = (r_state == ST_GOT_E0) || (r_state == ST_GOT_E0F0);
    assign w_brk   = byte_valid && !w_is_e0 && !w_is_f0 &&
                     ((r_state == ST_GOT_F0) || (r_state == ST_GOT_E0F0));
    assign w_make  = byte_valid && !w_is_e0 && !w_is_f0 &&
                     ((r_state == ST_GOT_E0) || (r_state == ST_IDLE && !ps2_is_ignored(byte_in)));
    assign w_match = key_pressed && (scan_code == byte_in) && (key_extended == w_ext);

`ifdef PS2_DEC_REPEAT_EN
    assign w_count = w_make;
`else
    assign w_count = w_make && !w_match;
`endif

    ps2_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk   (clk),
        .rstn  (rstn),
        .i_clr (byte_valid || r_state == ST_IDLE),
        .i_en  (r_state != ST_IDLE),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            scan_code     <= 8'h00;
            key_extended  <= 1'b0;
            key_pressed   <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= 8'h00;
            timeout_pulse <= 1'b0;
        end else begin
            press_pulse   <= w_count;
            release_pulse <= w_brk;
            timeout_pulse <= w_tc;
            if (w_count)
                press_count <= press_count + 8'd1;
            // A new key replaces the held one; a break only clears an exact match.
            if (w_make && !w_match) begin
                scan_code    <= byte_in;
                key_extended <= w_ext;
                key_pressed  <= 1'b1;
            end else if (w_brk && w_match) begin
                scan_code    <= 8'h00;
                key_extended <= 1'b0;
                key_pressed  <= 1'b0;
            end
            if (byte_valid)
                r_state <= w_is_f0 ? (r_state == ST_IDLE   ? ST_GOT_F0   :
                                      r_state == ST_GOT_E0 ? ST_GOT_E0F0 : r_state) :
                           w_is_e0 ? (r_state == ST_IDLE   ? ST_GOT_E0   : r_state) :
                           ST_IDLE;
            else if (w_tc)
                r_state <= ST_IDLE;
        end
    end

endmodule
